main_mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 12 +
 rtl/mem_latency_pipe.sv | 24 ++
 rtl/main_mem_responder.sv | 82 ++++++++
 tb/tb_main_mem_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the cache-fill memory interface: default geometry,
// request-type encoding and the refill block size.
package mem_pkg;
  localparam int MEM_ADDR_W      = 16;
  localparam int MEM_DATA_W      = 16;
  localparam int MEM_LATENCY     = 4;
  localparam int MEM_WORDS       = 32768;
  localparam int MEM_BLOCK_WORDS = 8;

  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;
endpackage

// File: rtl/mem_latency_pipe.sv
// Fixed-depth shift register of {valid, data} tokens; a synchronous clear
// drops every token in flight.
module mem_latency_pipe #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);
  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_dout = r_stage[DEPTH-1];
endmodule

// File: rtl/main_mem_responder.sv
// Pipelined main memory behind the I/D-cache refill path: writes commit at
// issue, reads return in order a fixed LATENCY cycles after issue.
module main_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int WORDS   = MEM_WORDS,
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [3:0]        inflight
);
  // Handshake: a request is taken on every edge where enable=1 (no ready
  // signal, never stalled); data_valid is a one-cycle pulse per read, in order.
  localparam int IDX_W = ADDR_W - 1;

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_hold;
  logic [3:0]        r_inflight;

  logic [IDX_W-1:0]  w_idx;
  logic              w_in_range;
  logic              w_rd_issue;
  logic              w_wr_issue;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W:0]   w_pipe_out;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;

  assign w_idx      = addr[ADDR_W-1:1];
  assign w_in_range = (32'(w_idx) < 32'(WORDS));
  assign w_rd_issue = enable && (wr == REQ_RD);
  assign w_wr_issue = enable && (wr == REQ_WR) && w_in_range;
  // Read captures the array before this edge's write lands.
  assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

  always_ff @(posedge clk) begin
    if (!rst && w_wr_issue) r_mem[w_idx] <= data_in;
  end

  mem_latency_pipe #(
    .DEPTH (LATENCY),
    .WIDTH (DATA_W + 1)
  ) u_pipe (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_din  ({w_rd_issue, w_rd_word}),
    .o_dout (w_pipe_out)
  );

  assign w_out_valid = w_pipe_out[DATA_W];
  assign w_out_data  = w_pipe_out[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst)              r_hold <= '0;
    else if (w_out_valid) r_hold <= w_out_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_rd_issue, w_out_valid})
        2'b10:   r_inflight <= r_inflight + 4'd1;
        2'b01:   r_inflight <= r_inflight - 4'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign data_valid = w_out_valid;
  assign data_out   = w_out_valid ? w_out_data : r_hold;
  assign inflight   = r_inflight;
endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: a request-level memory model with an
// expected-response queue, checked every cycle, plus literal spot checks.
module tb_main_mem_responder;
  import mem_pkg::*;

  localparam int L       = 4;
  localparam int WORDS_T = 32000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        data_valid;
  logic [3:0]  inflight;

  // clock / reset
  always #5 clk = ~clk;

  main_mem_responder #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .WORDS   (WORDS_T),
    .LATENCY (L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .inflight   (inflight)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: pending reads as (due edge, data); memory as a sparse map
  logic [15:0] exp_q[$];
  int          due_q[$];
  logic [15:0] mmem [int];
  logic [15:0] m_hold = '0;
  int          edge_n = 0;
  bit          chk_on = 1'b0;

  always @(posedge clk) begin
    int          idx;
    logic [15:0] rd;
    edge_n++;
    idx = int'(addr[15:1]);
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      m_hold = '0;
      chk_on = 1'b1;
    end else begin
      if (due_q.size() > 0 && due_q[0] == edge_n - 1) begin
        m_hold = exp_q.pop_front();
        void'(due_q.pop_front());
      end
      if (enable && wr) begin
        if (idx < WORDS_T) mmem[idx] = data_in;
      end else if (enable) begin
        rd = (idx < WORDS_T && mmem.exists(idx)) ? mmem[idx] : 16'h0000;
        exp_q.push_back(rd);
        due_q.push_back(edge_n + L - 1);
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    if (chk_on) begin
      ev = (due_q.size() > 0) && (due_q[0] == edge_n);
      chk("data_valid", 32'(data_valid), 32'(ev));
      chk("data_out", 32'(data_out), ev ? 32'(exp_q[0]) : 32'(m_hold));
      chk("inflight", 32'(inflight), 32'(due_q.size()));
    end
  end

  // driver tasks
  task automatic drive(input logic e, input logic w, input logic [15:0] a, input logic [15:0] d);
    enable = e; wr = w; addr = a; data_in = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_valid", 32'(data_valid), 32'd0);
    chk("reset_data", 32'(data_out), 32'd0);
    chk("reset_inflight", 32'(inflight), 32'd0);

    // write then read-after-write, 4-cycle latency
    drive(1'b1, REQ_WR, 16'h0010, 16'hBEEF);
    drive(1'b1, REQ_RD, 16'h0010, 16'h0000);
    chk("t1_infl_a", 32'(inflight), 32'd1);
    idle(2);
    chk("t1_infl_b", 32'(inflight), 32'd1);
    idle(1);
    chk("t1_valid", 32'(data_valid), 32'd1);
    chk("t1_data", 32'(data_out), 32'hBEEF);
    idle(1);
    chk("t1_valid_off", 32'(data_valid), 32'd0);
    chk("t1_infl_end", 32'(inflight), 32'd0);
    chk("t1_hold", 32'(data_out), 32'hBEEF);

    // 8-word block fill, back to back
    for (int i = 0; i < 8; i++) drive(1'b1, REQ_WR, 16'(2 * i), 16'(16'h1000 + i));
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, REQ_RD, 16'(2 * i), 16'h0000);
      if (i == 3) begin
        chk("t2_peak", 32'(inflight), 32'd4);
        chk("t2_first", 32'(data_out), 32'h1000);
      end
    end
    chk("t2_mid", 32'(data_out), 32'h1004);
    idle(3);
    chk("t2_last", 32'(data_out), 32'h1007);
    chk("t2_last_valid", 32'(data_valid), 32'd1);
    idle(1);

    // read followed by write to the same word returns old data
    drive(1'b1, REQ_WR, 16'h0020, 16'h1111);
    drive(1'b1, REQ_RD, 16'h0020, 16'h0000);
    drive(1'b1, REQ_WR, 16'h0020, 16'h2222);
    idle(2);
    chk("t3_old", 32'(data_out), 32'h1111);
    drive(1'b1, REQ_RD, 16'h0020, 16'h0000);
    idle(3);
    chk("t3_new", 32'(data_out), 32'h2222);
    idle(1);

    // reset mid-flight; write presented during reset is ignored
    drive(1'b1, REQ_WR, 16'h0030, 16'h3333);
    drive(1'b1, REQ_RD, 16'h0030, 16'h0000);
    drive(1'b1, REQ_RD, 16'h0010, 16'h0000);
    rst = 1'b1;
    drive(1'b1, REQ_WR, 16'h0010, 16'hDEAD);
    rst = 1'b0;
    chk("t4_valid", 32'(data_valid), 32'd0);
    chk("t4_infl", 32'(inflight), 32'd0);
    chk("t4_data", 32'(data_out), 32'd0);
    idle(5);
    drive(1'b1, REQ_RD, 16'h0010, 16'h0000);
    idle(3);
    chk("t4_retained", 32'(data_out), 32'hBEEF);
    idle(1);

    // alternating read / idle / write with gaps
    drive(1'b1, REQ_RD, 16'h0000, 16'h0000);
    idle(1);
    drive(1'b1, REQ_WR, 16'h0040, 16'h4444);
    drive(1'b1, REQ_RD, 16'h0002, 16'h0000);
    idle(2);
    drive(1'b1, REQ_RD, 16'h0040, 16'h0000);
    idle(1);
    drive(1'b1, REQ_WR, 16'h0042, 16'h5555);
    drive(1'b1, REQ_RD, 16'h0042, 16'h0000);
    idle(5);

    // odd address maps to the same word
    drive(1'b1, REQ_WR, 16'h0010, 16'hA5A5);
    drive(1'b1, REQ_RD, 16'h0011, 16'h0000);
    idle(3);
    chk("t6_valid", 32'(data_valid), 32'd1);
    chk("t6_odd", 32'(data_out), 32'hA5A5);
    idle(1);

    // word index at and below the depth boundary
    drive(1'b1, REQ_WR, 16'hFA00, 16'h1234);
    drive(1'b1, REQ_WR, 16'hF9FE, 16'h7777);
    drive(1'b1, REQ_RD, 16'hFA00, 16'h0000);
    drive(1'b1, REQ_RD, 16'hF9FE, 16'h0000);
    idle(2);
    chk("t7_oor_valid", 32'(data_valid), 32'd1);
    chk("t7_oor_zero", 32'(data_out), 32'h0000);
    idle(1);
    chk("t7_last_word", 32'(data_out), 32'h7777);
    idle(1);
    chk("t7_hold", 32'(data_out), 32'h7777);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
